// File: rtl/arbitro_perfil_n.sv
// Profile-priority arbiter: users post (function, profile) requests, and the highest
// profile wins a fixed-length grant. Ties rotate round-robin, and same-function rivals are rejected.
module arbitro_perfil_n #(
  parameter int N_USR    = 2,
  parameter int W_PERF   = 3,
  parameter int HOLD_CYC = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_USR*W_PERF-1:0]   perf_i,
  input  logic [2*N_USR-1:0]        fun_i,
  input  logic [N_USR-1:0]          req_vld_i,
  output logic [N_USR-1:0]          gnt_o,
  output logic [1:0]                gnt_fun_o,
  output logic [W_PERF-1:0]         gnt_perf_o,
  output logic [N_USR-1:0]          pend_o,
  output logic                      err_perf_o,
  output logic [3:0]                conf_cnt_o,
  output logic [1:0]                state_o
);

  localparam int IW = (N_USR > 1) ? $clog2(N_USR) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_REL = 2'd2} state_t;

  state_t                          state_q, state_d;
  logic [N_USR-1:0]                pend_q, pend_d;
  logic [N_USR-1:0][1:0]           fun_q, fun_d;
  logic [N_USR-1:0][W_PERF-1:0]    perf_q, perf_d;
  logic [N_USR-1:0]                gnt_q, gnt_d;
  logic [1:0]                      gnt_fun_q, gnt_fun_d;
  logic [W_PERF-1:0]               gnt_perf_q, gnt_perf_d;
  logic [IW-1:0]                   win_q, win_d;
  logic [IW-1:0]                   rr_q, rr_d;
  logic [HW-1:0]                   hold_q, hold_d;
  logic                            err_q, err_d;
  logic [3:0]                      conf_q, conf_d;

  logic                            found;
  logic [IW-1:0]                   best_idx;
  logic [W_PERF-1:0]               best_perf;
  int                              idx;
  logic                            cancel;
  logic [W_PERF-1:0]               u_perf;
  logic [1:0]                      u_fun;
  logic                            any_inv, any_acc, any_rej;

  // Scan from rr_q upward; strict '>' keeps the earliest user in rotation order on ties.
  always_comb begin
    found     = 1'b0;
    best_idx  = '0;
    best_perf = '0;
    idx       = 0;
    for (int j = 0; j < N_USR; j++) begin
      idx = (int'(rr_q) + j) % N_USR;
      if (pend_q[idx] && (!found || perf_q[idx] > best_perf)) begin
        found     = 1'b1;
        best_idx  = IW'(idx);
        best_perf = perf_q[idx];
      end
    end
  end

  assign cancel = (state_q == ST_GRANT) && req_vld_i[win_q] &&
                  (perf_i[win_q*W_PERF +: W_PERF] != '0) && (fun_i[win_q*2 +: 2] == 2'd0);

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    fun_d      = fun_q;
    perf_d     = perf_q;
    gnt_d      = gnt_q;
    gnt_fun_d  = gnt_fun_q;
    gnt_perf_d = gnt_perf_q;
    win_d      = win_q;
    rr_d       = rr_q;
    hold_d     = hold_q;
    err_d      = err_q;
    conf_d     = conf_q;
    any_inv    = 1'b0;
    any_acc    = 1'b0;
    any_rej    = 1'b0;
    u_perf     = '0;
    u_fun      = '0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d          = ST_GRANT;
          win_d            = best_idx;
          gnt_d            = '0;
          gnt_d[best_idx]  = 1'b1;
          gnt_fun_d        = fun_q[best_idx];
          gnt_perf_d       = perf_q[best_idx];
          hold_d           = HW'(HOLD_CYC - 1);
          for (int i = 0; i < N_USR; i++) begin
            if (pend_q[i] && (IW'(i) != best_idx) && (fun_q[i] == fun_q[best_idx])) begin
              pend_d[i] = 1'b0;
              any_rej   = 1'b1;
            end
          end
          if (any_rej && (conf_q != 4'd15)) conf_d = conf_q + 4'd1;
        end
      end
      ST_GRANT: begin
        if (cancel || (hold_q == '0)) begin
          state_d    = ST_REL;
          gnt_d      = '0;
          gnt_fun_d  = '0;
          gnt_perf_d = '0;
          hold_d     = '0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_REL: begin
        state_d       = ST_IDLE;
        pend_d[win_q] = 1'b0;
        rr_d          = (win_q == IW'(N_USR - 1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are applied last so a fresh request overrides a same-edge rejection.
    for (int i = 0; i < N_USR; i++) begin
      u_perf = perf_i[i*W_PERF +: W_PERF];
      u_fun  = fun_i[2*i +: 2];
      if (req_vld_i[i]) begin
        if (u_perf == '0) begin
          any_inv = 1'b1;
        end else if (u_fun == 2'd0) begin
          pend_d[i] = 1'b0;
        end else if (!((state_q != ST_IDLE) && (win_q == IW'(i)))) begin
          pend_d[i] = 1'b1;
          fun_d[i]  = u_fun;
          perf_d[i] = u_perf;
          any_acc   = 1'b1;
        end
      end
    end

    if (any_inv)      err_d = 1'b1;
    else if (any_acc) err_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      fun_q      <= '0;
      perf_q     <= '0;
      gnt_q      <= '0;
      gnt_fun_q  <= '0;
      gnt_perf_q <= '0;
      win_q      <= '0;
      rr_q       <= '0;
      hold_q     <= '0;
      err_q      <= 1'b0;
      conf_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      fun_q      <= fun_d;
      perf_q     <= perf_d;
      gnt_q      <= gnt_d;
      gnt_fun_q  <= gnt_fun_d;
      gnt_perf_q <= gnt_perf_d;
      win_q      <= win_d;
      rr_q       <= rr_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
      conf_q     <= conf_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign gnt_fun_o  = gnt_fun_q;
  assign gnt_perf_o = gnt_perf_q;
  assign pend_o     = pend_q;
  assign err_perf_o = err_q;
  assign conf_cnt_o = conf_q;
  assign state_o    = state_q;

endmodule
